// File: rtl/sync_sig_bank.sv
// Multi-channel synchronizer for asynchronous levels entering the clk domain, with
// per-channel AND-qualify or debounce filtering, edge pulses and a saturating edge counter.
module sync_sig_bank #(
    parameter int                CH_NUM      = 4,
    parameter int                SHIFT_WIDTH = 2,
    parameter logic [CH_NUM-1:0] DEB_EN      = {CH_NUM{1'b0}},
    parameter int                DEB_CNT_W   = 4,
    parameter logic [CH_NUM-1:0] RST_VAL     = {CH_NUM{1'b0}},
    parameter int                EVT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CH_NUM-1:0]    in_sig,
    input  logic [DEB_CNT_W-1:0] deb_len,
    input  logic                 cnt_clr,
    output logic [CH_NUM-1:0]    out_sig,
    output logic [CH_NUM-1:0]    rise_pulse,
    output logic [CH_NUM-1:0]    fall_pulse,
    output logic [EVT_W-1:0]     evt_cnt
);

    localparam int N_W   = $clog2(CH_NUM + 1);
    localparam int SUM_W = EVT_W + N_W;
    localparam logic [SUM_W-1:0] EVT_MAX = {{N_W{1'b0}}, {EVT_W{1'b1}}};

    function automatic logic [N_W-1:0] popcount(input logic [CH_NUM-1:0] v);
        logic [N_W-1:0] n;
        n = {N_W{1'b0}};
        for (int i = 0; i < CH_NUM; i++) begin
            n = n + N_W'(v[i]);
        end
        return n;
    endfunction

    logic [DEB_CNT_W-1:0] thr_s;
    logic [CH_NUM-1:0]    filt_s;
    logic [CH_NUM-1:0]    out_d_r;
    logic [EVT_W-1:0]     evt_cnt_r;
    logic [SUM_W-1:0]     evt_sum_s;
    logic [EVT_W-1:0]     evt_nxt_s;

    // Debounce threshold minus one; a zero length behaves as one cycle
    always_comb begin
        if (deb_len == {DEB_CNT_W{1'b0}}) begin
            thr_s = {DEB_CNT_W{1'b0}};
        end else begin
            thr_s = deb_len - DEB_CNT_W'(1'b1);
        end
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        logic [SHIFT_WIDTH-1:0] chain_r;

        // Synchronizer chain, bit 0 samples the asynchronous input
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                chain_r <= {SHIFT_WIDTH{RST_VAL[g]}};
            end else begin
                chain_r <= {chain_r[SHIFT_WIDTH-2:0], in_sig[g]};
            end
        end

        if (DEB_EN[g]) begin : g_deb
            logic                 st_r;
            logic [DEB_CNT_W-1:0] cnt_r;
            logic                 s_s;
            assign s_s = chain_r[SHIFT_WIDTH-1];

            // Debounce state: >= compare lets a shortened deb_len apply mid-count
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    st_r  <= RST_VAL[g];
                    cnt_r <= {DEB_CNT_W{1'b0}};
                end else if (s_s == st_r) begin
                    cnt_r <= {DEB_CNT_W{1'b0}};
                end else if (cnt_r >= thr_s) begin
                    st_r  <= s_s;
                    cnt_r <= {DEB_CNT_W{1'b0}};
                end else begin
                    cnt_r <= cnt_r + DEB_CNT_W'(1'b1);
                end
            end
            assign filt_s[g] = st_r;
        end else begin : g_and
            logic and_r;

            // Rise needs every stage high; any low stage clears on the next edge
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    and_r <= RST_VAL[g];
                end else begin
                    and_r <= &chain_r;
                end
            end
            assign filt_s[g] = and_r;
        end
    end

    // Delayed copy of the filtered level for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_d_r <= RST_VAL;
        end else begin
            out_d_r <= filt_s;
        end
    end

    assign out_sig    = filt_s;
    assign rise_pulse = filt_s & ~out_d_r;
    assign fall_pulse = ~filt_s & out_d_r;

    // Saturating next value of the edge counter
    always_comb begin
        evt_sum_s = {{N_W{1'b0}}, evt_cnt_r} + SUM_W'(popcount(rise_pulse | fall_pulse));
        if (evt_sum_s > EVT_MAX) begin
            evt_nxt_s = {EVT_W{1'b1}};
        end else begin
            evt_nxt_s = evt_sum_s[EVT_W-1:0];
        end
    end

    // Edge counter; a clear drops the events of its own cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_cnt_r <= {EVT_W{1'b0}};
        end else if (cnt_clr) begin
            evt_cnt_r <= {EVT_W{1'b0}};
        end else begin
            evt_cnt_r <= evt_nxt_s;
        end
    end

    assign evt_cnt = evt_cnt_r;

endmodule

// File: tb/tb_sync_sig_bank.sv
// Scoreboard bench for sync_sig_bank: instance A (RST_VAL=0, EVT_W=16) and
// instance B (RST_VAL=1111, EVT_W=3), channel 2 in debounce mode on both.
module tb_sync_sig_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n_a, rst_n_b, clr_a, clr_b;
    logic [3:0] in_a, in_b, len_a, len_b;
    logic [3:0] out_a, rise_a, fall_a, out_b, rise_b, fall_b;
    logic [15:0] evt_a;
    logic [2:0]  evt_b;

    sync_sig_bank #(.CH_NUM(4), .SHIFT_WIDTH(2), .DEB_EN(4'b0100), .DEB_CNT_W(4),
                    .RST_VAL(4'b0000), .EVT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .in_sig(in_a), .deb_len(len_a), .cnt_clr(clr_a),
        .out_sig(out_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .evt_cnt(evt_a));

    sync_sig_bank #(.CH_NUM(4), .SHIFT_WIDTH(2), .DEB_EN(4'b0100), .DEB_CNT_W(4),
                    .RST_VAL(4'b1111), .EVT_W(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .in_sig(in_b), .deb_len(len_b), .cnt_clr(clr_b),
        .out_sig(out_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .evt_cnt(evt_b));

    typedef struct {
        int          at;
        int          sel;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] probe(input int sel);
        case (sel)
            0: return 32'(out_a);
            1: return 32'(rise_a);
            2: return 32'(fall_a);
            3: return 32'(evt_a);
            4: return 32'(out_b);
            5: return 32'(rise_b);
            6: return 32'(fall_b);
            7: return 32'(evt_b);
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic push(input int dc, input int sel, input logic [31:0] v, input string tag);
        exp_t e;
        e.at = cyc + dc; e.sel = sel; e.val = v; e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic exp_a(input int dc, input logic [3:0] o, input logic [3:0] r,
                         input logic [3:0] f, input string tag);
        push(dc, 0, 32'(o), {tag, "_out_a"});
        push(dc, 1, 32'(r), {tag, "_rise_a"});
        push(dc, 2, 32'(f), {tag, "_fall_a"});
    endtask

    task automatic exp_b(input int dc, input logic [3:0] o, input logic [3:0] r,
                         input logic [3:0] f, input string tag);
        push(dc, 4, 32'(o), {tag, "_out_b"});
        push(dc, 5, 32'(r), {tag, "_rise_b"});
        push(dc, 6, 32'(f), {tag, "_fall_b"});
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard consumer: compare every entry due at this cycle
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].at == cyc) begin
                chk(sb_q[i].tag, probe(sb_q[i].sel), sb_q[i].val);
                sb_q.delete(i);
            end
        end
    end

    initial begin
        rst_n_a = 1'b0; rst_n_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        in_a = 4'b0000; in_b = 4'b0000; len_a = 4'd4; len_b = 4'd0;
        step(2);
        rst_n_a = 1'b1;
        exp_a(1, 4'b0000, 4'b0000, 4'b0000, "rst");
        push(1, 3, 32'd0, "rst_evt_a");
        step(3);

        // AND-mode rise then fast fall on channel 0
        in_a = 4'b0001;
        exp_a(2, 4'b0000, 4'b0000, 4'b0000, "t1_e2");
        exp_a(3, 4'b0001, 4'b0001, 4'b0000, "t1_e3");
        exp_a(4, 4'b0001, 4'b0000, 4'b0000, "t1_e4");
        push(4, 3, 32'd1, "t1_evt1");
        step(6);
        in_a = 4'b0000;
        exp_a(1, 4'b0001, 4'b0000, 4'b0000, "t1_f1");
        exp_a(2, 4'b0000, 4'b0000, 4'b0001, "t1_f2");
        exp_a(3, 4'b0000, 4'b0000, 4'b0000, "t1_f3");
        push(3, 3, 32'd2, "t1_evt2");
        step(5);

        // One-sample glitch on channel 1 never propagates
        in_a = 4'b0010;
        for (int d = 1; d <= 6; d++) exp_a(d, 4'b0000, 4'b0000, 4'b0000, "t2_glitch");
        push(6, 3, 32'd2, "t2_evt");
        step(1);
        in_a = 4'b0000;
        step(6);

        // Debounce channel 2, deb_len=4: 3-cycle bounces are rejected
        for (int rep = 0; rep < 2; rep++) begin
            in_a = 4'b0100;
            for (int d = 1; d <= 9; d++) exp_a(d, 4'b0000, 4'b0000, 4'b0000, "t3_bounce");
            push(9, 3, 32'd2, "t3_bounce_evt");
            step(3);
            in_a = 4'b0000;
            step(7);
        end
        in_a = 4'b0100;
        exp_a(5, 4'b0000, 4'b0000, 4'b0000, "t3_e5");
        exp_a(6, 4'b0100, 4'b0100, 4'b0000, "t3_e6");
        exp_a(7, 4'b0100, 4'b0000, 4'b0000, "t3_e7");
        push(7, 3, 32'd3, "t3_evt3");
        step(8);
        len_a = 4'd0;
        in_a = 4'b0000;
        exp_a(2, 4'b0100, 4'b0000, 4'b0000, "t3_len0_e2");
        exp_a(3, 4'b0000, 4'b0000, 4'b0100, "t3_len0_e3");
        push(4, 3, 32'd4, "t3_evt4");
        step(6);

        // All channels together, then a clear colliding with events
        in_a = 4'b1111;
        exp_a(2, 4'b0000, 4'b0000, 4'b0000, "t4_e2");
        exp_a(3, 4'b1111, 4'b1111, 4'b0000, "t4_e3");
        exp_a(4, 4'b1111, 4'b0000, 4'b0000, "t4_e4");
        push(4, 3, 32'd8, "t4_evt8");
        step(6);
        in_a = 4'b0000;
        exp_a(2, 4'b0100, 4'b0000, 4'b1011, "t4_f2");
        exp_a(3, 4'b0000, 4'b0000, 4'b0100, "t4_f3");
        push(3, 3, 32'd11, "t4_evt11");
        push(4, 3, 32'd0, "t4_clr");
        push(5, 3, 32'd0, "t4_after_clr");
        step(3);
        clr_a = 1'b1;
        step(1);
        clr_a = 1'b0;
        step(3);

        // Shortening deb_len mid-count takes effect on the next edge
        len_a = 4'd8;
        in_a = 4'b0100;
        exp_a(5, 4'b0000, 4'b0000, 4'b0000, "t3m_e5");
        exp_a(6, 4'b0100, 4'b0100, 4'b0000, "t3m_e6");
        push(7, 3, 32'd1, "t3m_evt");
        step(5);
        len_a = 4'd2;
        step(3);
        len_a = 4'd0;
        in_a = 4'b0000;
        exp_a(3, 4'b0000, 4'b0000, 4'b0100, "t3m_fall");
        push(4, 3, 32'd2, "t3m_evt2");
        step(6);

        // Instance B: RST_VAL=1111 released with inputs low
        rst_n_b = 1'b1;
        exp_b(1, 4'b1111, 4'b0000, 4'b0000, "t6_rel");
        push(1, 7, 32'd0, "t6_rel_evt");
        exp_b(2, 4'b0100, 4'b0000, 4'b1011, "t6_e2");
        exp_b(3, 4'b0000, 4'b0000, 4'b0100, "t6_e3");
        push(3, 7, 32'd3, "t6_evt3");
        push(4, 7, 32'd4, "t6_evt4");
        step(6);

        // EVT_W=3 saturation over nine edges, then clear
        clr_b = 1'b1;
        push(1, 7, 32'd0, "t5_clr0");
        step(1);
        clr_b = 1'b0;
        in_b = 4'b1111;
        exp_b(3, 4'b1111, 4'b1111, 4'b0000, "t5_rise");
        push(4, 7, 32'd4, "t5_evt4");
        step(6);
        in_b = 4'b0000;
        exp_b(2, 4'b0100, 4'b0000, 4'b1011, "t5_f2");
        exp_b(3, 4'b0000, 4'b0000, 4'b0100, "t5_f3");
        push(3, 7, 32'd7, "t5_evt7");
        push(4, 7, 32'd7, "t5_sat8");
        step(6);
        in_b = 4'b0001;
        exp_b(3, 4'b0001, 4'b0001, 4'b0000, "t5_r9");
        push(4, 7, 32'd7, "t5_sat9");
        step(6);
        clr_b = 1'b1;
        push(1, 7, 32'd0, "t5_clr");
        step(1);
        clr_b = 1'b0;
        step(2);

        // Reset in the middle of a debounce count
        len_b = 4'd8;
        in_b = 4'b0101;
        exp_b(4, 4'b0001, 4'b0000, 4'b0000, "t6_mid");
        step(5);
        rst_n_b = 1'b0;
        exp_b(1, 4'b1111, 4'b0000, 4'b0000, "t6_inrst");
        push(1, 7, 32'd0, "t6_inrst_evt");
        step(2);
        rst_n_b = 1'b1;
        exp_b(1, 4'b1111, 4'b0000, 4'b0000, "t6_rel2");
        exp_b(2, 4'b0101, 4'b0000, 4'b1010, "t6_resync");
        push(3, 7, 32'd2, "t6_resync_evt");
        step(6);
        in_b = 4'b0001;
        exp_b(9, 4'b0101, 4'b0000, 4'b0000, "t6_deb_e9");
        exp_b(10, 4'b0001, 4'b0000, 4'b0100, "t6_deb_e10");
        push(11, 7, 32'd3, "t6_deb_evt");
        step(12);

        for (int k = 0; k < 50 && sb_q.size() > 0; k++) step(1);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
